// File: rtl/rv32i_types.sv
// Shared types for the rv32i memory subsystem.
// Holds the cache-to-memory arbiter state encoding and grant identifiers.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical memory port between the I-cache and D-cache.
// The granted request is latched, so the memory side never sees requester changes mid-transaction.
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [31:0]       i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t        state_r;
  arb_state_t        state_next_s;
  logic              last_grant_r;
  logic [31:0]       addr_r;
  logic [LINE_W-1:0] wdata_r;
  logic              cmd_write_r;
  logic              d_req_s;
  logic              grant_s;

  // Next-state selection; a tie in IDLE goes to the side not granted last.
  always_comb begin
    state_next_s = state_r;
    d_req_s      = d_read | d_write;
    case (state_r)
      IDLE: begin
        if (i_read && d_req_s) begin
          if (last_grant_r == GRANT_I) begin
            state_next_s = SERVE_D;
          end else begin
            state_next_s = SERVE_I;
          end
        end else if (i_read) begin
          state_next_s = SERVE_I;
        end else if (d_req_s) begin
          state_next_s = SERVE_D;
        end else begin
          state_next_s = IDLE;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: state_next_s = IDLE;
    endcase
    grant_s = (state_r == IDLE) && (state_next_s != IDLE);
  end

  // State register, grant history and request latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= GRANT_I;
      addr_r       <= 32'h0000_0000;
      wdata_r      <= {LINE_W{1'b0}};
      cmd_write_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (grant_s) begin
        if (state_next_s == SERVE_D) begin
          last_grant_r <= GRANT_D;
          addr_r       <= d_address;
          wdata_r      <= d_wdata;
          // write wins when a D request is malformed with both commands set
          cmd_write_r  <= d_write;
        end else begin
          last_grant_r <= GRANT_I;
          addr_r       <= i_address;
          wdata_r      <= {LINE_W{1'b0}};
          cmd_write_r  <= 1'b0;
        end
      end else begin
        last_grant_r <= last_grant_r;
        addr_r       <= addr_r;
        wdata_r      <= wdata_r;
        cmd_write_r  <= cmd_write_r;
      end
    end
  end

  // Memory commands come only from latched state; responses route to the served side.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    pmem_address = addr_r;
    pmem_wdata   = wdata_r;
    i_rdata      = pmem_rdata;
    d_rdata      = pmem_rdata;
    if (state_r != IDLE) begin
      pmem_read  = ~cmd_write_r;
      pmem_write = cmd_write_r;
    end else begin
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
    end
    if (state_r == SERVE_I) begin
      i_resp = pmem_resp;
    end else if (state_r == SERVE_D) begin
      d_resp = pmem_resp;
    end else begin
      i_resp = 1'b0;
      d_resp = 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
module tb_cache_arbiter;

  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read;
  logic [31:0]       i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [31:0]       d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [31:0]       pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  cache_arbiter #(.LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [LINE_W-1:0] obs,
                          input logic [LINE_W-1:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
  endtask

  // Drives one serve phase starting in the first SERVE cycle; memory answers in cycle lat.
  task automatic run_txn(input string tag, input logic [31:0] exp_addr, input logic exp_write,
                         input logic [LINE_W-1:0] exp_wdata, input logic exp_d,
                         input logic [LINE_W-1:0] rdata, input int lat);
    for (int c = 1; c <= lat; c++) begin
      pmem_resp  = (c == lat);
      pmem_rdata = rdata;
      @(negedge clk);
      check_eq({tag, "_pmem_read"},  pmem_read,  !exp_write);
      check_eq({tag, "_pmem_write"}, pmem_write, exp_write);
      check_eq({tag, "_addr"},       pmem_address, exp_addr);
      if (exp_write) check_eq({tag, "_wdata"}, pmem_wdata, exp_wdata);
      check_eq({tag, "_i_resp"}, i_resp, (c == lat) && !exp_d);
      check_eq({tag, "_d_resp"}, d_resp, (c == lat) && exp_d);
      if (c == lat) begin
        check_eq({tag, "_i_rdata"}, i_rdata, rdata);
        check_eq({tag, "_d_rdata"}, d_rdata, rdata);
      end
      next_cyc();
    end
    pmem_resp = 1'b0;
  endtask

  initial begin
    logic [LINE_W-1:0] pat_a5;
    logic [LINE_W-1:0] pat_w0;
    logic [LINE_W-1:0] pat_w1;
    logic [LINE_W-1:0] pat_w2;
    pat_a5 = {8{32'hA5A5_A5A5}};
    pat_w0 = {8{32'h1234_5678}};
    pat_w1 = {8{32'hDEAD_BEEF}};
    pat_w2 = {8{32'h0F0F_5A5A}};

    rst = 1'b1; i_read = 1'b0; i_address = 32'h0; d_read = 1'b0; d_write = 1'b0;
    d_address = 32'h0; d_wdata = {LINE_W{1'b0}}; pmem_rdata = {LINE_W{1'b0}}; pmem_resp = 1'b0;
    next_cyc();
    do_reset();
    @(negedge clk);
    check_eq("rst_pmem_read",  pmem_read,    1'b0);
    check_eq("rst_pmem_write", pmem_write,   1'b0);
    check_eq("rst_pmem_addr",  pmem_address, 32'h0);
    check_eq("rst_pmem_wdata", pmem_wdata,   {LINE_W{1'b0}});
    check_eq("rst_i_resp",     i_resp,       1'b0);
    check_eq("rst_d_resp",     d_resp,       1'b0);
    next_cyc();

    // Single I-cache read, dropped after grant; memory answers in cycle 5
    i_read = 1'b1; i_address = 32'h0000_0060;
    @(negedge clk);
    check_eq("i_rd_lat0", pmem_read, 1'b0);
    next_cyc();
    i_read = 1'b0;
    run_txn("i_rd", 32'h0000_0060, 1'b0, {LINE_W{1'b0}}, 1'b0, pat_a5, 5);
    @(negedge clk);
    check_eq("i_rd_idle", pmem_read, 1'b0);
    next_cyc();

    // Stray memory response while idle
    pmem_resp = 1'b1;
    @(negedge clk);
    check_eq("idle_resp_i", i_resp, 1'b0);
    check_eq("idle_resp_d", d_resp, 1'b0);
    next_cyc();
    pmem_resp = 1'b0;
    @(negedge clk);
    check_eq("idle_resp_rd", pmem_read,  1'b0);
    check_eq("idle_resp_wr", pmem_write, 1'b0);
    next_cyc();

    // Round robin: first tie after reset to D, held requests then give I
    do_reset();
    i_read = 1'b1; i_address = 32'h0000_0040; d_read = 1'b1; d_address = 32'h0000_0080;
    next_cyc();
    run_txn("tie1_d", 32'h0000_0080, 1'b0, {LINE_W{1'b0}}, 1'b1, pat_w1, 1);
    @(negedge clk);
    check_eq("tie_gap", pmem_read, 1'b0);
    next_cyc();
    run_txn("tie2_i", 32'h0000_0040, 1'b0, {LINE_W{1'b0}}, 1'b0, pat_w2, 1);
    i_read = 1'b0; d_read = 1'b0;
    next_cyc();

    // D writeback; wdata/address changes after grant must not leak
    d_write = 1'b1; d_address = 32'h0000_0100; d_wdata = pat_w0;
    next_cyc();
    d_write = 1'b0; d_wdata = pat_w1; d_address = 32'h0000_0F00;
    run_txn("d_wr", 32'h0000_0100, 1'b1, pat_w0, 1'b1, pat_a5, 3);
    next_cyc();

    // Reset in cycle 3 of an I read abandons it
    i_read = 1'b1; i_address = 32'h0000_0300;
    next_cyc();
    i_read = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      check_eq("abort_pre_rd", pmem_read, 1'b1);
      next_cyc();
    end
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    pmem_resp = 1'b1;
    @(negedge clk);
    check_eq("abort_rd",     pmem_read,    1'b0);
    check_eq("abort_addr",   pmem_address, 32'h0);
    check_eq("abort_i_resp", i_resp,       1'b0);
    check_eq("abort_d_resp", d_resp,       1'b0);
    next_cyc();
    pmem_resp = 1'b0;
    @(negedge clk);
    check_eq("abort_after", pmem_read, 1'b0);
    next_cyc();

    // Both D commands set: one write only
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_0200; d_wdata = pat_w2;
    next_cyc();
    d_read = 1'b0; d_write = 1'b0;
    run_txn("d_rw", 32'h0000_0200, 1'b1, pat_w2, 1'b1, pat_w0, 2);
    @(negedge clk);
    check_eq("d_rw_done_wr", pmem_write, 1'b0);
    check_eq("d_rw_done_rd", pmem_read,  1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
